// File: rtl/riscv_fetch_queue_if.sv
// Fetch-stage bus bundle.
// Groups the instruction-memory request/response channel, the IF/ID
// handoff and the redirect input of riscv_fetch_queue.
//   master : the fetch stage (drives requests and the decode-side head entry)
//   slave  : memory / decode / branch-resolution environment
interface riscv_fetch_queue_if #(
  parameter int XLEN = 64
);
  logic            imem_req_valid;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_req_ready;
  logic            imem_resp_valid;
  logic [31:0]     imem_resp_data;
  logic            if_valid;
  logic [31:0]     if_instr;
  logic [XLEN-1:0] if_pc;
  logic            id_ready;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_resp_valid, imem_resp_data,
    output if_valid, if_instr, if_pc,
    input  id_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_resp_valid, imem_resp_data,
    input  if_valid, if_instr, if_pc,
    output id_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/riscv_fetch_queue.sv
// Instruction fetch stage with a prefetch queue.
// Generates sequential PCs, issues requests on a valid/ready channel, takes
// in-order responses into a DEPTH-entry (instr, pc) FIFO that feeds IF/ID,
// and on a redirect flushes the queue, discards every outstanding response
// and restarts fetching at the new PC.
// Ports:
//   clock : posedge clock
//   reset : asynchronous active-high reset, clears all control state
//   bus   : riscv_fetch_queue_if.master (imem req/resp, if_*, id_ready, redirect_*)
module riscv_fetch_queue #(
  parameter int              DEPTH    = 4,
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                clock,
  input  logic                reset,
  riscv_fetch_queue_if.master bus
);
  localparam int              AW      = $clog2(DEPTH);
  localparam int              CW      = AW + 1;
  localparam logic [31:0]     NOP     = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] r_resp_pc;
  logic [31:0]     r_instr [DEPTH];
  logic [XLEN-1:0] r_pc    [DEPTH];
  logic [AW-1:0]   r_rd_ptr;
  logic [AW-1:0]   r_wr_ptr;
  logic [CW-1:0]   r_count;
  logic [CW-1:0]   r_pending;
  logic [CW-1:0]   r_drop;

  logic            w_req_valid;
  logic            w_req_fire;
  logic            w_resp;
  logic            w_drop_nz;
  logic            w_enq;
  logic            w_if_valid;
  logic            w_pop;
  logic [CW:0]     w_inflight;
  logic [CW-1:0]   w_count_nxt;
  logic [CW-1:0]   w_pending_nxt;
  logic [XLEN-1:0] w_redirect_pc;

  // Queued plus in-flight fetches never exceed DEPTH, so the FIFO cannot overflow.
  assign w_inflight    = {1'b0, r_count} + {1'b0, r_pending};
  assign w_req_valid   = !reset && !bus.redirect_valid && (w_inflight < (CW+1)'(DEPTH));
  assign w_req_fire    = w_req_valid && bus.imem_req_ready;
  assign w_resp        = bus.imem_resp_valid;
  assign w_drop_nz     = (r_drop != '0);
  assign w_enq         = w_resp && !w_drop_nz;
  assign w_if_valid    = (r_count != '0) && !bus.redirect_valid;
  assign w_pop         = w_if_valid && bus.id_ready;
  assign w_count_nxt   = r_count + CW'(w_enq) - CW'(w_pop);
  assign w_pending_nxt = r_pending + CW'(w_req_fire) - CW'(w_resp);
  assign w_redirect_pc = {bus.redirect_pc[XLEN-1:2], 2'b00};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_fetch_pc <= RESET_PC;
      r_resp_pc  <= RESET_PC;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_pending  <= '0;
      r_drop     <= '0;
    end else if (bus.redirect_valid) begin
      // No request fires in a redirect cycle, so every request still
      // outstanding after this edge belongs to the old stream: drop them all.
      r_fetch_pc <= w_redirect_pc;
      r_resp_pc  <= w_redirect_pc;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_pending  <= w_pending_nxt;
      r_drop     <= w_pending_nxt;
    end else begin
      if (w_req_fire) r_fetch_pc <= r_fetch_pc + PC_STEP;
      if (w_enq) begin
        r_resp_pc <= r_resp_pc + PC_STEP;
        r_wr_ptr  <= r_wr_ptr + AW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_resp && w_drop_nz) r_drop <= r_drop - CW'(1);
      r_count   <= w_count_nxt;
      r_pending <= w_pending_nxt;
    end
  end

  // Payload storage carries no reset; occupancy is tracked by r_count.
  always_ff @(posedge clock) begin
    if (w_enq && !bus.redirect_valid) begin
      r_instr[r_wr_ptr] <= bus.imem_resp_data;
      r_pc[r_wr_ptr]    <= r_resp_pc;
    end
  end

  assign bus.imem_req_valid = w_req_valid;
  assign bus.imem_req_addr  = r_fetch_pc;
  assign bus.if_valid       = w_if_valid;
  assign bus.if_instr       = w_if_valid ? r_instr[r_rd_ptr] : NOP;
  assign bus.if_pc          = w_if_valid ? r_pc[r_rd_ptr] : '0;
endmodule

// File: tb/tb_riscv_fetch_queue.sv
// Bench for riscv_fetch_queue: behavioural memory with programmable
// latency returning addr>>2, a scoreboard of expected decode PCs refilled on
// every reset/redirect, a negedge monitor that pops it on each IF/ID
// handshake, and directed phases with hand-computed cycle checks.
module tb_riscv_fetch_queue;
  localparam logic [63:0] RST_PC = 64'h0;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic clock;
  logic reset;
  riscv_fetch_queue_if #(.XLEN(64)) bus();

  riscv_fetch_queue #(.DEPTH(4), .XLEN(64), .RESET_PC(RST_PC)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- memory model ----------------
  typedef struct packed {
    logic [63:0] addr;
    logic [31:0] due;
  } mreq_t;
  mreq_t mq[$];
  int    cyc;
  int    lat;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      mq.delete();
      cyc                 <= 0;
      bus.imem_resp_valid <= 1'b0;
      bus.imem_resp_data  <= 32'h0;
    end else begin
      cyc <= cyc + 1;
      if (bus.imem_req_valid && bus.imem_req_ready)
        mq.push_back({bus.imem_req_addr, 32'(cyc + lat)});
      if (mq.size() != 0 && mq[0].due <= 32'(cyc + 1)) begin
        bus.imem_resp_valid <= 1'b1;
        bus.imem_resp_data  <= mq[0].addr[33:2];
        void'(mq.pop_front());
      end else begin
        bus.imem_resp_valid <= 1'b0;
      end
    end
  end

  // ---------------- scoreboard ----------------
  logic [63:0] exp_q[$];

  task automatic restart(input logic [63:0] pc);
    exp_q.delete();
    for (int i = 0; i < 128; i++) exp_q.push_back(pc + 64'(4 * i));
  endtask

  always @(negedge clock) begin
    if (!reset && bus.if_valid && bus.id_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_underflow: got pc 0x%0h, expected no pop", bus.if_pc);
      end else begin
        check("sb_pc", bus.if_pc, exp_q[0]);
        check("sb_instr", {32'h0, bus.if_instr}, {32'h0, exp_q[0][33:2]});
        void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset(input int l, input logic idr, input logic rdy);
    reset              = 1'b1;
    lat                = l;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 64'h0;
    bus.id_ready       = idr;
    bus.imem_req_ready = rdy;
    restart(RST_PC);
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic wait_first(input string name, input logic [63:0] pc);
    int w;
    w = 0;
    while (!bus.if_valid && w < 10) begin
      step();
      #1;
      w++;
    end
    check({name, "_valid"}, bus.if_valid, 1);
    check({name, "_pc"}, bus.if_pc, pc);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected end of run");
    $fatal(1, "watchdog expired");
  end

  logic [63:0] a0;
  int          bad;

  initial begin
    reset              = 1'b1;
    lat                = 1;
    bus.imem_req_ready = 1'b0;
    bus.id_ready       = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 64'h0;
    restart(RST_PC);
    #12;
    check("rst_if_valid", bus.if_valid, 0);
    check("rst_if_instr", bus.if_instr, NOP);
    check("rst_if_pc", bus.if_pc, 0);
    check("rst_req_valid", bus.imem_req_valid, 0);

    // Free run, 1-cycle memory, decode always ready.
    do_reset(1, 1'b1, 1'b1);
    #1;
    check("fr_req_valid_c0", bus.imem_req_valid, 1);
    check("fr_req_addr_c0", bus.imem_req_addr, RST_PC);
    step();
    step();
    #1;
    check("fr_if_valid_c2", bus.if_valid, 1);
    check("fr_if_pc_c2", bus.if_pc, 0);
    check("fr_if_instr_c2", bus.if_instr, 0);
    bad = 0;
    repeat (10) begin
      step();
      #1;
      if (!bus.if_valid) bad++;
    end
    check("fr_bubbles", 64'(bad), 0);

    // Decode stalled: queue fills to DEPTH, then drains without loss.
    do_reset(1, 1'b0, 1'b1);
    repeat (6) step();
    #1;
    check("full_req_valid", bus.imem_req_valid, 0);
    check("full_count", 64'(dut.r_count), 4);
    check("full_head_pc", bus.if_pc, 0);
    bus.id_ready = 1'b1;
    step();
    #1;
    check("full_resume_valid", bus.imem_req_valid, 1);
    check("full_resume_addr", bus.imem_req_addr, 64'h10);
    repeat (10) step();

    // 3-cycle memory, redirect with two queued and two in flight.
    do_reset(3, 1'b0, 1'b1);
    step();
    step();
    bus.imem_req_ready = 1'b0;
    step();
    bus.imem_req_ready = 1'b1;
    step();
    step();
    #1;
    check("rd3_pre_count", 64'(dut.r_count), 2);
    check("rd3_pre_pending", 64'(dut.r_pending), 2);
    check("rd3_pre_resp", bus.imem_resp_valid, 0);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h103;
    restart(64'h100);
    #1;
    check("rd3_if_valid", bus.if_valid, 0);
    check("rd3_req_valid", bus.imem_req_valid, 0);
    step();
    bus.redirect_valid = 1'b0;
    bus.id_ready       = 1'b1;
    #1;
    check("rd3_new_valid", bus.imem_req_valid, 1);
    check("rd3_new_addr", bus.imem_req_addr, 64'h100);
    check("rd3_drop", 64'(dut.r_drop), 2);
    check("rd3_q_empty", bus.if_valid, 0);
    wait_first("rd3_first", 64'h100);
    repeat (4) step();

    // Redirect coincident with a response and a ready decode stage.
    do_reset(2, 1'b1, 1'b1);
    repeat (8) step();
    #1;
    check("rdc_pre_resp", bus.imem_resp_valid, 1);
    check("rdc_pre_pending", 64'(dut.r_pending), 2);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h200;
    restart(64'h200);
    step();
    bus.redirect_valid = 1'b0;
    #1;
    check("rdc_drop", 64'(dut.r_drop), 1);
    check("rdc_count", 64'(dut.r_count), 0);
    check("rdc_pending", 64'(dut.r_pending), 1);
    check("rdc_addr", bus.imem_req_addr, 64'h200);
    wait_first("rdc_first", 64'h200);
    repeat (6) step();

    // Memory refuses requests for 5 cycles.
    bus.imem_req_ready = 1'b0;
    #1;
    a0 = bus.imem_req_addr;
    check("stall_req_valid", bus.imem_req_valid, 1);
    for (int i = 1; i < 5; i++) begin
      step();
      #1;
      check("stall_addr_hold", bus.imem_req_addr, a0);
    end
    check("stall_if_valid", bus.if_valid, 0);
    check("stall_if_instr", bus.if_instr, NOP);
    check("stall_if_pc", bus.if_pc, 0);
    step();
    bus.imem_req_ready = 1'b1;
    repeat (8) step();

    // Asynchronous reset mid-stream with two requests in flight.
    check("arst_pre_pending", 64'(dut.r_pending), 2);
    #1;
    reset = 1'b1;
    #1;
    check("arst_if_valid", bus.if_valid, 0);
    check("arst_if_instr", bus.if_instr, NOP);
    check("arst_if_pc", bus.if_pc, 0);
    check("arst_req_valid", bus.imem_req_valid, 0);
    restart(RST_PC);
    step();
    reset = 1'b0;
    #1;
    check("arst_req_valid_c0", bus.imem_req_valid, 1);
    check("arst_req_addr_c0", bus.imem_req_addr, RST_PC);
    wait_first("arst_first", RST_PC);
    repeat (5) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
